// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, fetch FSM state type and the
// shift-and-add framebuffer address helper.
package vga_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_TOT  = 800;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_TOT  = 525;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        SCAN       = 2'd2
    } state_t;

    // y*320 + x as (y<<8)+(y<<6)+x; largest result 239*320+319 = 76799.
    function automatic logic [16:0] pix_addr(input logic [8:0] x, input logic [8:0] y);
        return {y, 8'b0} + {2'b0, y, 6'b0} + {8'b0, x};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical counters with raw (undelayed) active-low
// syncs and the active-region flag.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS = 640,
    parameter int V_VIS = 480
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [9:0] o_h_cnt,
    output logic [9:0] o_v_cnt,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_active
);

    // Blanking intervals stay at their standard lengths when the visible area is resized.
    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign o_h_cnt   = r_h_cnt;
    assign o_v_cnt   = r_v_cnt;
    assign o_hsync_n = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign o_vsync_n = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    assign o_active  = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);

endmodule

// File: rtl/pixel_fetch.sv
// Scan-out of a 2x-upscaled greyscale framebuffer onto VGA: address generation,
// frame FSM and a one-cycle output stage aligned with synchronous RAM data.
module pixel_fetch
    import vga_pkg::*;
#(
    parameter int H_VIS = 640,
    parameter int V_VIS = 480,
    parameter int SRC_W = 320,
    parameter int SRC_H = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [16:0] fb_addr,
    input  logic [7:0]  fb_data,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        Hsync,
    output logic        Vsync,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [8:0] SRC_W_C = 9'(SRC_W);
    localparam logic [8:0] SRC_H_C = 9'(SRC_H);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);

    logic [9:0] w_h_cnt;
    logic [9:0] w_v_cnt;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic       w_active;
    logic [8:0] w_x;
    logic [8:0] w_y;
    logic       w_in_src;
    logic       w_origin;
    logic       w_frame_end;
    logic       w_frame_done;
    state_t     w_state_next;

    state_t     r_state;
    logic       r_hsync_p1;
    logic       r_vsync_p1;
    logic       r_pix_en_p1;

    vga_timing #(
        .H_VIS (H_VIS),
        .V_VIS (V_VIS)
    ) u_timing (
        .i_clk     (clk),
        .i_reset   (reset),
        .o_h_cnt   (w_h_cnt),
        .o_v_cnt   (w_v_cnt),
        .o_hsync_n (w_hsync_n),
        .o_vsync_n (w_vsync_n),
        .o_active  (w_active)
    );

    assign w_x         = w_h_cnt[9:1];
    assign w_y         = w_v_cnt[9:1];
    assign w_in_src    = w_active && (w_x < SRC_W_C) && (w_y < SRC_H_C);
    assign w_origin    = (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);
    assign w_frame_end = (w_h_cnt == 10'd0) && (w_v_cnt == V_VIS_C);
    assign fb_addr     = w_in_src ? pix_addr(w_x, w_y) : 17'd0;

    // Next state is used for pixel enable so pixel (0,0) of the first frame is shown.
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE:       if (start) w_state_next = WAIT_FRAME;
            WAIT_FRAME: if (w_origin) w_state_next = SCAN;
            SCAN: begin
                if (w_frame_end) begin
                    w_frame_done = 1'b1;
                    w_state_next = start ? WAIT_FRAME : IDLE;
                end
            end
            default:    w_state_next = IDLE;
        endcase
    end

    // Stage p1: control aligned with fb_data returned by the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hsync_p1  <= 1'b1;
            r_vsync_p1  <= 1'b1;
            r_pix_en_p1 <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hsync_p1  <= w_hsync_n;
            r_vsync_p1  <= w_vsync_n;
            r_pix_en_p1 <= w_in_src && (w_state_next == SCAN);
        end
    end

    assign R          = r_pix_en_p1 ? fb_data : 8'd0;
    assign G          = R;
    assign B          = R;
    assign Hsync      = r_hsync_p1;
    assign Vsync      = r_vsync_p1;
    assign busy       = (r_state != IDLE);
    assign frame_done = w_frame_done;

endmodule
